// File: rtl/udp_rx_pkt_fifo.sv
// udp_rx_pkt_fifo: packet-mode show-ahead FIFO with speculative writes, atomic commit and rollback
module udp_rx_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int AL_FULL_NUM = 1024,
  parameter int AL_EMPTY_NUM = 128,
  parameter bit DROP_ON_OVF = 1'b1,
  parameter logic [DATA_WIDTH-1:0] DOUT_INITVAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  we,
  input  logic                  commit,
  input  logic                  discard,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty_flag,
  output logic                  aempty,
  output logic                  full_flag,
  output logic                  afull,
  output logic                  valid,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  wr_success,
  output logic                  pkt_drop,
  output logic [ADDR_WIDTH:0]   rdusedw,
  output logic [ADDR_WIDTH:0]   wrusedw
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [PW-1:0] rp, wp_cmt, wp_tmp, rp_n, wp_inc, wp_cmt_n, wp_tmp_n, rdusedw_n, wrusedw_n;
  logic ovf_err, wr_acc, rd_acc, ovf_now, conv_drop, drop, cmt, empty_n, fwd;
  always_comb begin
    wr_acc    = we && !full_flag;
    rd_acc    = re && !empty_flag;
    ovf_now   = ovf_err || (we && full_flag);
    conv_drop = commit && DROP_ON_OVF && ovf_now;
    drop      = discard || conv_drop;
    cmt       = commit && !drop;
    rp_n      = rp + PW'(rd_acc);
    wp_inc    = wp_tmp + PW'(wr_acc);
    wp_tmp_n  = drop ? wp_cmt : wp_inc;
    wp_cmt_n  = cmt ? wp_inc : wp_cmt;
    rdusedw_n = wp_cmt_n - rp_n;
    wrusedw_n = wp_tmp_n - rp_n;
    // empty lags a fresh non-zero count by one edge so the prefetch read can land
    empty_n   = (rdusedw_n == '0) || (rdusedw == '0);
    fwd       = wr_acc && (wp_tmp[ADDR_WIDTH-1:0] == rp_n[ADDR_WIDTH-1:0]);
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wp_tmp[ADDR_WIDTH-1:0]] <= di;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rp         <= '0;
      wp_cmt     <= '0;
      wp_tmp     <= '0;
      rdusedw    <= '0;
      wrusedw    <= '0;
      empty_flag <= 1'b1;
      aempty     <= 1'b1;
      full_flag  <= 1'b0;
      afull      <= 1'b0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      wr_success <= 1'b0;
      pkt_drop   <= 1'b0;
      ovf_err    <= 1'b0;
      dout       <= DOUT_INITVAL;
    end else begin
      rp         <= rp_n;
      wp_cmt     <= wp_cmt_n;
      wp_tmp     <= wp_tmp_n;
      rdusedw    <= rdusedw_n;
      wrusedw    <= wrusedw_n;
      empty_flag <= empty_n;
      aempty     <= 32'(rdusedw_n) <= AL_EMPTY_NUM;
      full_flag  <= wrusedw_n == DEPTH;
      afull      <= 32'(wrusedw_n) >= AL_FULL_NUM;
      valid      <= rd_acc;
      overflow   <= we && full_flag;
      underflow  <= re && empty_flag;
      wr_success <= wr_acc;
      pkt_drop   <= discard || (conv_drop && (wp_inc != wp_cmt));
      ovf_err    <= (commit || discard) ? 1'b0 : ovf_now;
      // a word committed together with a read of the last visible word is forwarded from di
      dout       <= empty_n ? DOUT_INITVAL : (fwd ? di : mem[rp_n[ADDR_WIDTH-1:0]]);
    end
endmodule

// File: tb/tb_udp_rx_pkt_fifo.sv
// tb_udp_rx_pkt_fifo: directed and random checks of udp_rx_pkt_fifo against a queue-based frame model
module tb_udp_rx_pkt_fifo;
  localparam logic [31:0] INIT = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, commit = 1'b0, discard = 1'b0, re = 1'b0;
  logic [31:0] di = '0, dout0, dout1;
  logic [4:0] rdw0, rdw1, wrw0, wrw1;
  logic emp0, emp1, aemp0, aemp1, ful0, ful1, afl0, afl1, vld0, vld1;
  logic ovf0, ovf1, und0, und1, wrs0, wrs1, drp0, drp1;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q_c[$], q_p[$];
  logic m_ovf, m_emp, x_vld, x_ovf, x_und, x_wrs, x_drp;

  always #5 clk = ~clk;

  udp_rx_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AL_FULL_NUM(12), .AL_EMPTY_NUM(2),
    .DROP_ON_OVF(1'b1), .DOUT_INITVAL(INIT)) d0 (
    .clk(clk), .rst_n(rst_n), .di(di), .we(we), .commit(commit), .discard(discard), .re(re),
    .dout(dout0), .empty_flag(emp0), .aempty(aemp0), .full_flag(ful0), .afull(afl0),
    .valid(vld0), .overflow(ovf0), .underflow(und0), .wr_success(wrs0), .pkt_drop(drp0),
    .rdusedw(rdw0), .wrusedw(wrw0));

  udp_rx_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AL_FULL_NUM(12), .AL_EMPTY_NUM(2),
    .DROP_ON_OVF(1'b0), .DOUT_INITVAL(INIT)) d1 (
    .clk(clk), .rst_n(rst_n), .di(di), .we(we), .commit(commit), .discard(discard), .re(re),
    .dout(dout1), .empty_flag(emp1), .aempty(aemp1), .full_flag(ful1), .afull(afl1),
    .valid(vld1), .overflow(ovf1), .underflow(und1), .wr_success(wrs1), .pkt_drop(drp1),
    .rdusedw(rdw1), .wrusedw(wrw1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_c.delete();
    q_p.delete();
    m_ovf = 0; m_emp = 1;
    x_vld = 0; x_ovf = 0; x_und = 0; x_wrs = 0; x_drp = 0;
  endtask

  task automatic check0();
    int nc, nt;
    nc = q_c.size();
    nt = q_c.size() + q_p.size();
    chk("rdusedw", 32'(rdw0), nc);
    chk("wrusedw", 32'(wrw0), nt);
    chk("empty_flag", 32'(emp0), 32'(m_emp));
    chk("full_flag", 32'(ful0), 32'(nt == 16));
    chk("afull", 32'(afl0), 32'(nt >= 12));
    chk("aempty", 32'(aemp0), 32'(nc <= 2));
    chk("dout", dout0, m_emp ? INIT : q_c[0]);
    chk("valid", 32'(vld0), 32'(x_vld));
    chk("overflow", 32'(ovf0), 32'(x_ovf));
    chk("underflow", 32'(und0), 32'(x_und));
    chk("wr_success", 32'(wrs0), 32'(x_wrs));
    chk("pkt_drop", 32'(drp0), 32'(x_drp));
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic c, input logic x, input logic r);
    logic full, wa, ra, on;
    int prev;
    we = w; di = d; commit = c; discard = x; re = r;
    @(posedge clk);
    full = (q_c.size() + q_p.size()) == 16;
    wa = w && !full;
    ra = r && !m_emp;
    prev = q_c.size();
    x_vld = ra; x_ovf = w && full; x_und = r && m_emp; x_wrs = wa; x_drp = 0;
    if (ra) void'(q_c.pop_front());
    if (wa) q_p.push_back(d);
    on = m_ovf || (w && full);
    if (x) begin
      x_drp = 1;
      q_p.delete();
    end else if (c) begin
      if (on) x_drp = q_p.size() != 0;
      else foreach (q_p[i]) q_c.push_back(q_p[i]);
      q_p.delete();
    end
    m_ovf = (c || x) ? 1'b0 : on;
    m_emp = (q_c.size() == 0) || (prev == 0);
    #1;
    check0();
    we = 0; commit = 0; discard = 0; re = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check0();
    // 1: uncommitted words stay invisible, commit publishes them
    for (int i = 0; i < 5; i++) step(1, 32'h10 + i, 0, 0, 0);
    chk("t1_empty_pending", 32'(emp0), 1);
    chk("t1_wrusedw", 32'(wrw0), 5);
    step(0, 0, 1, 0, 0);
    chk("t1_rdusedw_commit", 32'(rdw0), 5);
    chk("t1_empty_lag", 32'(emp0), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_empty_clear", 32'(emp0), 0);
    chk("t1_dout_head", dout0, 32'h10);
    // 2: discard with a same-cycle write rolls the whole frame back
    for (int i = 0; i < 3; i++) step(1, 32'hA0 + i, 0, 0, 0);
    step(1, 32'hA3, 0, 1, 0);
    chk("t2_wrusedw_rollback", 32'(wrw0), 5);
    chk("t2_pkt_drop", 32'(drp0), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, !m_emp);
    chk("t2_drained", 32'(rdw0), 0);
    // 3: a frame longer than the depth overflows
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'h300 + i, 0, 0, 0);
    chk("t3_full", 32'(ful0), 1);
    step(1, 32'h3FF, 0, 0, 0);
    chk("t3_overflow", 32'(ovf0), 1);
    chk("t3_overflow_nodrop", 32'(ovf1), 1);
    step(0, 0, 1, 0, 0);
    chk("t3_drop_conv", 32'(drp0), 1);
    chk("t3_rdusedw_drop", 32'(rdw0), 0);
    chk("t3_rdusedw_keep", 32'(rdw1), 16);
    chk("t3_keep_no_drop", 32'(drp1), 0);
    // 4: random frames against a continuous reader
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int len, act;
      len = $urandom_range(1, 6);
      act = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        logic last;
        last = (i == len - 1);
        step(1, $urandom, last && act == 1, last && act == 2, !m_emp);
      end
      if (act == 0) step(0, 0, 1, 0, !m_emp);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, !m_emp);
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, !m_emp);
    chk("t4_drained", 32'(rdw0), 0);
    // 5: underflow, valid, almost-empty / almost-full thresholds
    do_reset();
    step(0, 0, 0, 0, 1);
    chk("t5_underflow", 32'(und0), 1);
    step(1, 32'hAB, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_dout", dout0, 32'hAB);
    step(0, 0, 0, 0, 1);
    chk("t5_valid", 32'(vld0), 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h500 + i, 1, 0, 0);
      if (i == 1) chk("t5_aempty_at2", 32'(aemp0), 1);
      if (i == 2) chk("t5_aempty_at3", 32'(aemp0), 0);
      if (i == 10) chk("t5_afull_at11", 32'(afl0), 0);
      if (i == 11) chk("t5_afull_at12", 32'(afl0), 1);
    end
    // 6: asynchronous reset mid-frame
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h600 + i, i == 3, 0, 0);
    step(1, 32'h6A, 0, 0, 0);
    step(1, 32'h6B, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_rdusedw", 32'(rdw0), 0);
    chk("t6_wrusedw", 32'(wrw0), 0);
    chk("t6_empty", 32'(emp0), 1);
    chk("t6_aempty", 32'(aemp0), 1);
    chk("t6_full", 32'(ful0), 0);
    chk("t6_afull", 32'(afl0), 0);
    chk("t6_dout", dout0, INIT);
    chk("t6_pulses", {27'd0, vld0, ovf0, und0, wrs0, drp0}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(1, 32'h60 + i, i == 2, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_dout_addr0", dout0, 32'h60);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, !m_emp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
